// File: rtl/timer_sequencer.sv
// Programmable 555-style pulse sequencer: astable (free-run or burst) or monostable
// output with configurable high/low phase lengths held in shadow registers.
module timer_sequencer #(
  parameter int CNT_W   = 16,
  parameter int BURST_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [CNT_W-1:0]   cfg_high,
  input  logic [CNT_W-1:0]   cfg_low,
  input  logic               cfg_mode,
  input  logic [BURST_W-1:0] cfg_burst,
  input  logic               start,
  input  logic               stop,
  output logic               pulse,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  output logic [BURST_W-1:0] period_cnt
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t             state;
  logic [CNT_W-1:0]   sh_high;
  logic [CNT_W-1:0]   sh_low;
  logic               sh_mode;
  logic [BURST_W-1:0] sh_burst;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   start_high;
  logic [BURST_W-1:0] period_inc;

  // A zero-length phase still lasts one cycle, so the reload value saturates at 0.
  function automatic logic [CNT_W-1:0] reload(input logic [CNT_W-1:0] len);
    return (len == '0) ? '0 : len - 1'b1;
  endfunction

  // A config write accompanying start applies to the run it launches.
  assign start_high = cfg_we ? cfg_high : sh_high;
  assign period_inc = period_cnt + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      sh_high    <= CNT_W'(1);
      sh_low     <= CNT_W'(1);
      sh_mode    <= 1'b0;
      sh_burst   <= '0;
      cnt        <= '0;
      pulse      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
      period_cnt <= '0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_we) begin
            sh_high  <= cfg_high;
            sh_low   <= cfg_low;
            sh_mode  <= cfg_mode;
            sh_burst <= cfg_burst;
          end
          if (start && !stop) begin
            state      <= HIGH;
            cnt        <= reload(start_high);
            pulse      <= 1'b1;
            busy       <= 1'b1;
            period_cnt <= '0;
          end
        end
        HIGH: begin
          if (stop) begin
            state <= IDLE;
            pulse <= 1'b0;
            busy  <= 1'b0;
          end else if (cnt == '0) begin
            pulse <= 1'b0;
            if (sh_mode) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= LOW;
              cnt   <= reload(sh_low);
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        LOW: begin
          if (stop) begin
            state <= IDLE;
            pulse <= 1'b0;
            busy  <= 1'b0;
          end else if (cnt == '0) begin
            period_cnt <= period_inc;
            if (sh_burst != '0 && period_inc == sh_burst) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= HIGH;
              cnt   <= reload(sh_high);
              pulse <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          pulse <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
      if (cfg_we && state != IDLE) cfg_err <= 1'b1;
    end
  end

endmodule

// File: doc/timer_sequencer.md
# timer_sequencer

Programmable run-time controller for the lab's 555-style pulse generation. It holds the high and low phase lengths in cycles and sequences the output as either a free-running/burst astable waveform or a one-shot monostable pulse. Start, stop and completion are handled with a single-cycle handshake. It sits between the lab's switch/register front end and the pulse consumer (LED, counter, buzzer), replacing fixed compile-time durations with configurable ones.

## Interface
- CNT_W, 16, width of phase-length registers and phase counter
- BURST_W, 8, width of burst-count register and period counter
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- cfg_we  input  1  load cfg_* into shadow registers (honoured only in IDLE)
- cfg_high  input  CNT_W  high-phase length in cycles
- cfg_low  input  CNT_W  low-phase length in cycles
- cfg_mode  input  1  0 = astable, 1 = monostable
- cfg_burst  input  BURST_W  astable period count; 0 = run until stop
- start  input  1  begin sequence (honoured only in IDLE)
- stop  input  1  abort sequence
- pulse  output  1  generated waveform, registered
- busy  output  1  high while not IDLE
- done  output  1  one-cycle completion strobe
- cfg_err  output  1  one-cycle strobe: cfg_we seen while busy
- period_cnt  output  BURST_W  completed periods in the current or last run

## Operation
- Reset values: shadow high = 1, low = 1, mode = 0, burst = 0. Outputs pulse = 0, busy = 0, done = 0, cfg_err = 0, period_cnt = 0. State = IDLE.
- Phase lengths of 0 are treated as 1, so the minimum phase is 1 cycle.
- States and transitions:
  - IDLE -> HIGH on start && !stop. The phase counter loads high-1, period_cnt clears.
  - HIGH: the counter decrements. At 0:
    - monostable: -> IDLE, with done.
    - astable: -> LOW, counter loads low-1.
  - LOW: the counter decrements. At 0:
    - period_cnt += 1.
    - burst != 0 and period_cnt+1 == burst: -> IDLE, with done.
    - otherwise: -> HIGH, counter loads high-1.
- stop in HIGH or LOW: -> IDLE next edge. pulse = 0, done is not asserted, period_cnt holds.
- Simultaneous events:
  - start and stop together in IDLE: stop wins, stays IDLE.
  - stop on the same edge as natural completion: stop wins, no done.
  - start while busy: ignored.
  - start in the same cycle done is high (first IDLE cycle): accepted.
- Config writes:
  - cfg_we in IDLE loads all four shadow fields at once.
  - cfg_we while busy is dropped and strobes cfg_err for 1 cycle; the running sequence is unaffected.
  - cfg_we and start together in IDLE: the new config is used for that run.
- period_cnt wraps modulo 2^BURST_W in free-run (burst = 0).
- Monostable leaves period_cnt at 0.
- Mid-operation reset (reset low): all registers return to reset values immediately; pulse drops asynchronously.

## Timing
- start sampled at edge N: pulse = 1 and busy = 1 from cycle N+1.
- pulse is high for exactly H cycles, then low for exactly L cycles, with no gap cycles between phases.
- Example, H = 3, L = 2, astable, burst = 2, start at edge 0:
  - pulse high in cycles 1–3 and 6–8, low in 4–5 and 9–10.
  - busy falls and done = 1 in cycle 11.
- Monostable, H = 3, start at edge 0: pulse high in cycles 1–3; done = 1 and busy = 0 in cycle 4.
- stop sampled at edge M: pulse = 0 and busy = 0 from cycle M+1.
- cfg_err is asserted in the cycle after the offending cfg_we.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then start with default config (H = 1, L = 1, astable, burst = 0) -> pulse toggles every cycle from cycle 1, busy = 1, period_cnt increments every 2 cycles and wraps 255 -> 0.
- cfg H = 3, L = 2, burst = 2, then start at edge 0 -> high 1–3 and 6–8, low 4–5 and 9–10, done = 1 only in cycle 11, period_cnt = 2.
- cfg monostable, H = 5 (L = 0) -> pulse high in cycles 1–5, done in cycle 6, period_cnt = 0; H = 0 gives a 1-cycle pulse.
- Free-run H = 4, L = 4, stop asserted in cycle 6 -> pulse = 0 and busy = 0 from cycle 7, no done. start and stop together in IDLE -> no activity.
- cfg_we with H = 10 during a run -> cfg_err is a 1-cycle strobe, the waveform keeps the old H; a write in IDLE afterwards -> the next run uses H = 10.
- Reset driven low mid-HIGH -> pulse, busy and period_cnt are 0 immediately; after release, start uses the default H = 1, L = 1.
